// File: rtl/button_iomem.sv
// button_iomem: debounced push-button peripheral with sticky W1C press/release
// events and a level interrupt, on the picosoc iomem bus.
//
// Ports:
//   clk          system clock
//   resetn       synchronous active-low reset
//   btn_raw      asynchronous button pins, bit order {C,D,L,R,U}
//   iomem_valid  request, already qualified by the top-level address decode
//   iomem_wstrb  byte write strobes, 0 = read
//   iomem_addr   byte address, only [3:2] decoded
//   iomem_wdata  write data
//   iomem_rdata  registered read data, held until the next access
//   iomem_ready  one-cycle completion pulse
//   btn_level    debounced level, 1 = pressed
//   irq          OR of (press_evt & irq_en)
//
// Register map (addr[3:2]):
//   0 STATUS  RO   [NBTN-1:0]   btn_level
//   1 EVENTS  W1C  [NBTN-1:0]   press_evt, [8+NBTN-1:8] rel_evt
//   2 IRQ_EN  RW   [NBTN-1:0]
//   3 reserved, reads 0
//
// Optional feature: define BTN_AUTOREPEAT_EN to re-raise press_evt while a
// button is held (first after REPEAT_DELAY cycles, then every REPEAT_RATE).
module button_iomem #(
    parameter int NBTN            = 5,
    parameter int DEBOUNCE_CYCLES = 648000,
    parameter bit ACTIVE_LOW      = 1'b0,
    parameter int REPEAT_DELAY    = 19440000,
    parameter int REPEAT_RATE     = 4536000
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [NBTN-1:0] btn_raw,
    input  logic            iomem_valid,
    input  logic [3:0]      iomem_wstrb,
    input  logic [31:0]     iomem_addr,
    input  logic [31:0]     iomem_wdata,
    output logic [31:0]     iomem_rdata,
    output logic            iomem_ready,
    output logic [NBTN-1:0] btn_level,
    output logic            irq
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic [NBTN-1:0] s1, s2, sync, stable, stable_nxt;
    logic [NBTN-1:0] press_evt, rel_evt, irq_en;
    logic [NBTN-1:0] press_set, rel_set, rpt_set, press_clr, rel_clr;
    logic [CW-1:0]   cnt [NBTN];
    logic [CW-1:0]   cnt_nxt [NBTN];
    logic [1:0]      sel;
    logic            acc;
    logic [31:0]     rd;
    logic            unused;

    assign unused = ^{iomem_addr[31:4], iomem_addr[1:0], iomem_wdata, iomem_wstrb[3:2]};

    assign sync      = ACTIVE_LOW ? ~s2 : s2;
    assign sel       = iomem_addr[3:2];
    assign acc       = iomem_valid && !iomem_ready;
    assign btn_level = stable;
    assign irq       = |(press_evt & irq_en);

    // A level is accepted only after it has differed from stable for
    // DEBOUNCE_CYCLES consecutive cycles; any return to stable restarts the count.
    always_comb begin
        for (int i = 0; i < NBTN; i++) begin
            stable_nxt[i] = stable[i];
            cnt_nxt[i]    = '0;
            if (sync[i] != stable[i]) begin
                if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1))
                    stable_nxt[i] = sync[i];
                else
                    cnt_nxt[i] = cnt[i] + 1'b1;
            end
        end
    end

    assign press_set = (stable_nxt & ~stable) | rpt_set;
    assign rel_set   = ~stable_nxt & stable;
    assign press_clr = (acc && sel == 2'd1 && iomem_wstrb[0]) ? iomem_wdata[NBTN-1:0] : '0;
    assign rel_clr   = (acc && sel == 2'd1 && iomem_wstrb[1]) ? iomem_wdata[8 +: NBTN] : '0;

    assign rd = sel == 2'd0 ? 32'(stable) :
                sel == 2'd1 ? (32'(rel_evt) << 8) | 32'(press_evt) :
                sel == 2'd2 ? 32'(irq_en) : 32'd0;

`ifdef BTN_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY);
    logic [RW-1:0] rpt [NBTN];

    // After the first repeat the counter reloads so that the next terminal
    // count arrives REPEAT_RATE cycles later.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NBTN; i++) begin
            if (!resetn || !stable[i])
                rpt[i] <= '0;
            else if (rpt[i] == RW'(REPEAT_DELAY - 1))
                rpt[i] <= RW'(REPEAT_DELAY - REPEAT_RATE);
            else
                rpt[i] <= rpt[i] + 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < NBTN; i++)
            rpt_set[i] = stable[i] && rpt[i] == RW'(REPEAT_DELAY - 1);
    end
`else
    assign rpt_set = '0;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            s1          <= '0;
            s2          <= '0;
            stable      <= '0;
            press_evt   <= '0;
            rel_evt     <= '0;
            irq_en      <= '0;
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
            for (int i = 0; i < NBTN; i++)
                cnt[i] <= '0;
        end else begin
            s1     <= btn_raw;
            s2     <= s1;
            stable <= stable_nxt;
            for (int i = 0; i < NBTN; i++)
                cnt[i] <= cnt_nxt[i];
            // Set is ORed after the clear so a same-cycle event survives W1C.
            press_evt <= (press_evt & ~press_clr) | press_set;
            rel_evt   <= (rel_evt & ~rel_clr) | rel_set;
            if (acc && sel == 2'd2 && iomem_wstrb[0])
                irq_en <= iomem_wdata[NBTN-1:0];
            iomem_ready <= acc;
            if (acc)
                iomem_rdata <= rd;
        end
    end
endmodule

// File: tb/tb_button_iomem.sv
// tb_button_iomem: directed self-checking bench for button_iomem.
module tb_button_iomem;
    localparam logic [31:0] STATUS = 32'h0, EVENTS = 32'h4, IRQ_EN = 32'h8, RSVD = 32'hC;

    logic        clk = 1'b0;
    logic        resetn;
    logic [4:0]  btn_raw;
    logic        iomem_valid;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;
    logic        iomem_ready;
    logic [4:0]  btn_level;
    logic        irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    button_iomem #(
        .NBTN(5), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b0), .REPEAT_DELAY(20), .REPEAT_RATE(8)
    ) dut (
        .clk(clk), .resetn(resetn), .btn_raw(btn_raw),
        .iomem_valid(iomem_valid), .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
        .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata), .iomem_ready(iomem_ready),
        .btn_level(btn_level), .irq(irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                       output logic [31:0] r);
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = a;
        iomem_wstrb = s;
        iomem_wdata = d;
        @(negedge clk);
        chk("ready_pulse", 32'(iomem_ready), 32'd1);
        iomem_valid = 1'b0;
        iomem_wstrb = 4'd0;
        r = iomem_rdata;
        @(negedge clk);
        chk("ready_drop", 32'(iomem_ready), 32'd0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        logic [31:0] r;
        bus(a, s, d, r);
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] r;
        bus(a, 4'd0, 32'd0, r);
        chk(tag, r, exp);
    endtask

    initial begin
        logic [31:0] r;
        int n;
        int cyc;
        resetn      = 1'b0;
        btn_raw     = '0;
        iomem_valid = 1'b0;
        iomem_wstrb = '0;
        iomem_addr  = '0;
        iomem_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(iomem_ready), 32'd0);
        chk("rst_rdata", iomem_rdata, 32'd0);
        chk("rst_level", 32'(btn_level), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        resetn = 1'b1;
        rd("idle_status", STATUS, 32'h0);
        rd("idle_events", EVENTS, 32'h0);
        chk("idle_irq", 32'(irq), 32'd0);

        btn_raw[2] = 1'b1;
        repeat (3) @(negedge clk);
        btn_raw[2] = 1'b0;
        repeat (10) @(negedge clk);
        chk("glitch_level", 32'(btn_level), 32'h0);
        rd("glitch_events", EVENTS, 32'h0);
        btn_raw[2] = 1'b1;
        repeat (5) @(negedge clk);
        chk("deb_not_yet", 32'(btn_level), 32'h0);
        @(negedge clk);
        chk("deb_level", 32'(btn_level), 32'h4);
        rd("deb_status", STATUS, 32'h4);
        rd("deb_events", EVENTS, 32'h4);
        btn_raw[2] = 1'b0;
        repeat (8) @(negedge clk);
        rd("rel2_events", EVENTS, 32'h0404);
        wr(EVENTS, 4'b0011, 32'h0404);
        rd("rel2_cleared", EVENTS, 32'h0);

        btn_raw[0] = 1'b1;
        repeat (8) @(negedge clk);
        btn_raw[0] = 1'b0;
        repeat (8) @(negedge clk);
        rd("b0_events", EVENTS, 32'h0101);
        wr(EVENTS, 4'b0010, 32'h0101);
        rd("lane1_only", EVENTS, 32'h0001);
        btn_raw[0] = 1'b1;
        repeat (4) @(negedge clk);
        wr(EVENTS, 4'b0001, 32'h1);
        rd("race_set_wins", EVENTS, 32'h1);
        wr(EVENTS, 4'b0001, 32'h1);
        rd("plain_clear", EVENTS, 32'h0);
        btn_raw[0] = 1'b0;
        repeat (8) @(negedge clk);
        wr(EVENTS, 4'b0011, 32'hFFFF);
        rd("b0_cleared", EVENTS, 32'h0);

        wr(IRQ_EN, 4'b0001, 32'h10);
        chk("irq_before", 32'(irq), 32'd0);
        btn_raw[4] = 1'b1;
        repeat (8) @(negedge clk);
        chk("irq_press", 32'(irq), 32'd1);
        btn_raw[4] = 1'b0;
        repeat (8) @(negedge clk);
        rd("b4_events", EVENTS, 32'h1010);
        bus(EVENTS, 4'b0001, 32'h10, r);
        chk("rdata_pre_clear", r, 32'h1010);
        chk("irq_cleared", 32'(irq), 32'd0);
        rd("b4_rel_left", EVENTS, 32'h1000);
        wr(EVENTS, 4'b0010, 32'hFF00);
        rd("b4_cleared", EVENTS, 32'h0);

        wr(IRQ_EN, 4'b1111, 32'h0);
        wr(IRQ_EN, 4'b0010, 32'hFFFFFFFF);
        rd("strb_hi_only", IRQ_EN, 32'h0);
        wr(IRQ_EN, 4'b0001, 32'hFFFFFFFF);
        rd("strb_lo", IRQ_EN, 32'h1F);
        chk("irq_no_evt", 32'(irq), 32'd0);
        rd("rsvd_read", RSVD, 32'h0);
        wr(RSVD, 4'b1111, 32'hFFFFFFFF);
        rd("rsvd_after_wr", RSVD, 32'h0);
        rd("irq_en_kept", IRQ_EN, 32'h1F);

        wr(IRQ_EN, 4'b0001, 32'h2);
        btn_raw[1] = 1'b1;
        n = 0;
        cyc = 0;
        while (cyc < 62) begin
            @(negedge clk);
            cyc++;
            if (irq) begin
                n++;
                wr(EVENTS, 4'b0001, 32'h2);
                cyc += 3;
            end
        end
        btn_raw[1] = 1'b0;
        repeat (8) @(negedge clk);
`ifdef BTN_AUTOREPEAT_EN
        chk("repeat_count", 32'(n), 32'd6);
`else
        chk("repeat_count", 32'(n), 32'd1);
`endif
        rd("b1_rel", EVENTS, 32'h0200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/button_iomem.md
Name: button_iomem

Overview:
- Button input peripheral on the picosoc iomem bus.
- Replaces the raw button read in the GPIO word.
- Synchronises and debounces NBTN push-buttons, and latches press/release events in sticky registers that firmware clears by writing 1.
- Raises a level interrupt so the game loop never misses a short press. Sits upstream of the CPU, in parallel with the GPIO and video slaves.

Parameters:
- NBTN, 5, number of buttons; bit order {C,D,L,R,U}.
- DEBOUNCE_CYCLES, 648000, stable cycles needed to accept a new level (10 ms @ 64.8 MHz); must be ≥2.
- ACTIVE_LOW, 0, 1 = raw pin low means pressed; inversion is applied after the synchroniser.
- REPEAT_DELAY, 19440000, cycles held before the first auto-repeat (300 ms); used only with the macro.
- REPEAT_RATE, 4536000, cycles between subsequent auto-repeats (70 ms); used only with the macro.

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset, synchronous, active-low.
- btn_raw  in  NBTN  asynchronous button pins.
- iomem_valid  in  1  request; already qualified by the top-level address decode (0x04xx_xxxx).
- iomem_wstrb  in  4  byte write strobes; 0 = read.
- iomem_addr  in  32  byte address; only [3:2] is decoded.
- iomem_wdata  in  32  write data.
- iomem_rdata  out  32  registered read data.
- iomem_ready  out  1  one-cycle completion pulse.
- btn_level  out  NBTN  debounced level, 1 = pressed.
- irq  out  1  OR of (press_evt & irq_en).

Behaviour:
- Reset (resetn=0 at clk edge) clears: sync flops, stable levels, all counters, press_evt, rel_evt, irq_en, iomem_ready, iomem_rdata. A reset in mid-debounce or mid-transaction aborts it; no ready is issued.
- Synchroniser: 2 FFs per bit, then optional inversion. Total input latency to sync value is 2 clk.
- Debounce, per button, counter cnt of width clog2(DEBOUNCE_CYCLES):
  - If sync == stable: cnt <= 0.
  - Otherwise cnt increments.
  - When cnt == DEBOUNCE_CYCLES-1 and sync still differs: stable <= sync and cnt <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES never changes stable.
- btn_level = stable (registered).
- Events:
  - stable 0→1 sets press_evt[i]; stable 1→0 sets rel_evt[i].
  - Bits are sticky until cleared.
  - If a set and a W1C clear of the same bit happen in the same cycle, the set wins.
- Register map (addr[3:2]):
  - 0 STATUS RO: [NBTN-1:0]=btn_level.
  - 1 EVENTS W1C: [NBTN-1:0]=press_evt, [8+NBTN-1:8]=rel_evt.
  - 2 IRQ_EN RW: [NBTN-1:0].
  - 3 reserved: reads 0, writes ignored.
  - Unused bits read 0. A write applies only to the lanes whose wstrb bit is set (byte 0 → bits 7:0, byte 1 → bits 15:8).
- Handshake:
  - In the cycle where iomem_valid && !iomem_ready, the block registers iomem_rdata, applies the write, and sets iomem_ready=1 on the next edge.
  - iomem_ready is 1 for exactly one cycle, then returns to 0.
  - Latency is 1 cycle; no back-to-back ready.
  - iomem_rdata holds its value until the next access.
  - A read of EVENTS returns the value before any clear in that same cycle.
- irq is combinational from registered state: |(press_evt & irq_en).

Optional Feature:
- Macro BTN_AUTOREPEAT_EN.
- Defined: each button has a repeat counter that clears when stable=0.
  - While stable=1, the counter counts.
  - At REPEAT_DELAY-1 it sets press_evt[i] and reloads for REPEAT_RATE.
  - It then sets press_evt[i] every REPEAT_RATE cycles until release.
  - A repeat that coincides with a W1C follows the "set wins" rule.
- Undefined: no repeat counters; press_evt is set only on a 0→1 edge.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8):
- Reset/idle: hold resetn=0 for 3 cycles, then release; read STATUS and EVENTS -> both 0x00000000, iomem_ready exactly 1 cycle after valid, irq=0.
- Debounce: btn_raw[2] high 3 cycles then low -> btn_level unchanged. High for 10 cycles -> btn_level[2]=1 within 2+4 cycles of the edge; EVENTS reads 0x00000004.
- W1C race: press_evt[0] set; write EVENTS=0x1 in the same cycle that a new edge on button 0 sets the bit -> EVENTS reads 0x1. A later write of 0x1 with no edge -> reads 0x0.
- Release/irq: IRQ_EN=0x10; press then release button 4 -> irq=1 after the press; EVENTS=0x1010; write 0x10 -> irq=0, EVENTS=0x1000.
- Byte strobes: write IRQ_EN=0xFFFFFFFF with wstrb=4'b0010 -> IRQ_EN reads 0x0. Write with wstrb=4'b0001 -> reads 0x1F. Read addr 0xC -> 0x0.
- Auto-repeat (macro on): hold button 1 for 60 cycles, clearing EVENTS after each set -> press_evt[1] is set at the press and at +20, +28, +36, +44, +52 cycles. With the macro off -> set only once.
